serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_if.sv | 24 ++
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake and result bundle between a requester and the bit-serial adder.
// The requester drives start/operands; the adder returns status and the registered result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic             co;

  modport master (
    output start, a, b, ci,
    input  busy, done, q, co
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, q, co
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice walks the operands LSB first, WIDTH cycles per add.
// start is only looked at in IDLE/DONE; requests arriving while busy are dropped, not queued.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] q_r;
  logic             carry;
  logic             co_r;
  logic [CW-1:0]    cnt;

  logic             bit_a;
  logic             bit_b;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Shared slice: operands are addressed by the counter rather than shifted.
  assign bit_a     = a_sr[cnt];
  assign bit_b     = b_sr[cnt];
  assign sum_bit   = bit_a ^ bit_b ^ carry;
  assign carry_nxt = (bit_a & bit_b) ^ ((bit_a ^ bit_b) & carry);
  assign res_nxt   = {sum_bit, res_sr[WIDTH-1:1]};
  assign last      = (state == RUN) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // q/co only move on the final slice edge, so a new add in flight leaves the old result visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      q_r    <= '0;
      carry  <= 1'b0;
      co_r   <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr  <= bus.a;
      b_sr  <= bus.b;
      carry <= bus.ci;
      cnt   <= '0;
    end else if (state == RUN) begin
      res_sr <= res_nxt;
      carry  <= carry_nxt;
      if (last) begin
        q_r  <= res_nxt;
        co_r <= carry_nxt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.q    = q_r;
  assign bus.co   = co_r;
endmodule
